// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N-bit stream mux with explicit-select and round-robin modes
module stream_mux_rr #(
    parameter int N        = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS*N-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    output logic [N-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      grant
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] cand;
    logic             cand_ok;
    logic             load;
    logic             accept;
    int               idx;

    assign load   = !out_valid || out_ready;
    assign accept = load && cand_ok && !rst;

    // Round-robin search starts one past the last accepted channel and wraps modulo CHANNELS.
    always_comb begin
        cand    = select;
        cand_ok = 1'b0;
        idx     = 0;
        if (!mode) begin
            if (int'(select) < CHANNELS)
                cand_ok = in_valid[select];
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                idx = (int'(ptr) + k) % CHANNELS;
                if (!cand_ok && in_valid[idx]) begin
                    cand_ok = 1'b1;
                    cand    = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++)
            in_ready[i] = accept && (cand == SEL_W'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant     <= '0;
            ptr       <= SEL_W'(CHANNELS - 1);
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(cand)*N +: N];
            grant     <= cand;
            ptr       <= cand;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized check of stream_mux_rr (4- and 3-channel builds) against a reference model
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data  = '0;
    logic [3:0]  in_valid = '0;
    logic        mode     = 1'b0;
    logic [1:0]  select   = '0;
    logic        out_ready = 1'b0;

    logic [3:0] rdy4;
    logic [7:0] od4;
    logic       ov4;
    logic [1:0] g4;
    logic [2:0] rdy3;
    logic [7:0] od3;
    logic       ov3;
    logic [1:0] g3;

    int n_tests = 0;
    int n_fail  = 0;

    int nch[2] = '{4, 3};
    int m_ptr[2];
    bit m_ov[2];
    int m_od[2];
    int m_g[2];

    always #5 clk = ~clk;

    stream_mux_rr #(.N(8), .CHANNELS(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
        .mode(mode), .select(select), .out_data(od4), .out_valid(ov4),
        .out_ready(out_ready), .grant(g4)
    );

    stream_mux_rr #(.N(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
        .mode(mode), .select(select), .out_data(od3), .out_valid(ov3),
        .out_ready(out_ready), .grant(g3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] act_rdy(int k);
        return (k == 0) ? {28'd0, rdy4} : {29'd0, rdy3};
    endfunction
    function automatic logic [31:0] act_ov(int k);
        return (k == 0) ? {31'd0, ov4} : {31'd0, ov3};
    endfunction
    function automatic logic [31:0] act_od(int k);
        return (k == 0) ? {24'd0, od4} : {24'd0, od3};
    endfunction
    function automatic logic [31:0] act_g(int k);
        return (k == 0) ? {30'd0, g4} : {30'd0, g3};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = nch[k] - 1;
            m_ov[k]  = 1'b0;
            m_od[k]  = 0;
            m_g[k]   = 0;
        end
    endtask

    // Which channel the rules pick this cycle, independent of the output register.
    task automatic model_cand(input int k, output bit ok, output int c);
        int n;
        n  = nch[k];
        ok = 1'b0;
        c  = int'(select);
        if (!mode) begin
            ok = (int'(select) < n) && in_valid[select];
        end else begin
            for (int off = 1; off <= n; off++) begin
                int ch;
                ch = (m_ptr[k] + off) % n;
                if (!ok && in_valid[ch]) begin
                    ok = 1'b1;
                    c  = ch;
                end
            end
        end
    endtask

    task automatic check_outputs(input string sfx);
        for (int k = 0; k < 2; k++) begin
            check({"out_valid", sfx}, act_ov(k), {31'd0, m_ov[k]});
            check({"out_data", sfx},  act_od(k), m_od[k]);
            check({"grant", sfx},     act_g(k),  m_g[k]);
        end
    endtask

    // Inputs are set by the caller just after a falling edge; this advances one rising edge.
    task automatic cycle();
        bit ok[2];
        int c[2];
        bit acc[2];
        bit ld;
        #1;
        for (int k = 0; k < 2; k++) begin
            model_cand(k, ok[k], c[k]);
            ld     = !m_ov[k] || out_ready;
            acc[k] = ld && ok[k];
            check(k == 0 ? "in_ready4" : "in_ready3", act_rdy(k), acc[k] ? (32'd1 << c[k]) : 32'd0);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                m_od[k]  = int'((in_data >> (c[k] * 8)) & 32'hff);
                m_g[k]   = c[k];
                m_ov[k]  = 1'b1;
                m_ptr[k] = c[k];
            end else if (!m_ov[k] || out_ready) begin
                m_ov[k] = 1'b0;
            end
        end
        @(negedge clk);
        check_outputs(k_sfx());
    endtask

    function automatic string k_sfx();
        return (mode ? "_rr" : "_sel");
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++)
            check("rst_in_ready", act_rdy(k), 32'd0);
        check_outputs("_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] held_d;
        logic [1:0] held_g;
        model_reset();
        do_reset();

        // explicit select of channel 2
        mode = 1'b0; select = 2'd2; in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b1;
        #1;
        check("sel2_in_ready", {28'd0, rdy4}, 32'h4);
        cycle();
        check("sel2_data", {24'd0, od4}, 32'hA5);
        check("sel2_grant", {30'd0, g4}, 32'd2);

        // fairness from a fresh reset
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; in_data = 32'h1312_1110; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("rr_seq4", {30'd0, g4}, i % 4);
            check("rr_data4", {24'd0, od4}, 32'h10 + (i % 4));
            check("rr_seq3", {30'd0, g3}, i % 3);
            check("rr_valid4", {31'd0, ov4}, 32'd1);
        end

        // hold with out_ready low while inputs churn
        held_d = od4; held_g = g4;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            select = 2'($urandom); in_data = $urandom; in_valid = 4'($urandom); mode = 1'($urandom);
            cycle();
            check("hold_data", {24'd0, od4}, {24'd0, held_d});
            check("hold_grant", {30'd0, g4}, {30'd0, held_g});
        end
        out_ready = 1'b1; mode = 1'b1; in_valid = 4'b1111;
        cycle();

        // sparse round-robin: only ch1 and ch3 valid
        mode = 1'b1; in_valid = 4'b1010; in_data = 32'hD3C2_B1A0;
        for (int i = 0; i < 5; i++) cycle();

        // select 3 is out of range on the 3-channel build
        mode = 1'b0; select = 2'd3; in_valid = 4'b1111;
        out_ready = 1'b0; cycle();
        out_ready = 1'b1; cycle(); cycle();
        check("oor_valid3", {31'd0, ov3}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            mode      = ($urandom_range(0, 3) != 0);
            select    = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // asynchronous reset mid-stream with a held word
        mode = 1'b1; in_valid = 4'b1111; in_data = 32'h4433_2211; out_ready = 1'b0;
        cycle(); cycle();
        check("pre_rst_valid", {31'd0, ov4}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_in_ready4", {28'd0, rdy4}, 32'd0);
        check_outputs("_arst");
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        cycle();
        check("post_rst_grant4", {30'd0, g4}, 32'd0);
        check("post_rst_grant3", {30'd0, g3}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised, registered N-bit stream multiplexer with CHANNELS inputs and one output. Each channel uses a valid/ready handshake.
- Channel choice has two modes:
  - Explicit select (the generalisation of the plain 4:1 mux).
  - Round-robin arbitration among valid channels.
- Sits between multiple producers (e.g. peripheral/UART/ALU result streams) and a single consumer. Provides one output register stage for timing isolation.

Parameters:
- N, 8, data width per channel in bits.
- CHANNELS, 4, number of input channels (>=2; need not be a power of two).
- SEL_W, $clog2(CHANNELS), width of select and grant.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*N  packed channel data; channel i at bits [i*N +: N].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready (combinational).
- mode  input  1  0 = explicit select, 1 = round-robin.
- select  input  SEL_W  channel index used when mode=0.
- out_data  output  N  registered output word.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- grant  output  SEL_W  registered index of the channel that produced out_data.

Behaviour:
- Reset (asynchronous on rst high, held while high):
  - out_valid=0, out_data=0, grant=0.
  - Internal last-accepted pointer ptr=CHANNELS-1, so the first round-robin search starts at channel 0.
- Load enable: load = !out_valid || out_ready, evaluated combinationally each cycle.
- Candidate channel, combinational:
  - mode=0: cand=select; cand_ok = (select < CHANNELS) && in_valid[select].
  - mode=1: search circularly from (ptr+1) mod CHANNELS. Take the first i with in_valid[i]=1. cand_ok=0 if no channel is valid.
- Ready: in_ready[i] = load && cand_ok && (cand==i). At most one bit of in_ready is high in any cycle.
- Accept: occurs on a rising edge where in_valid[cand] && in_ready[cand]. On accept:
  - out_data <= channel cand data.
  - grant <= cand.
  - out_valid <= 1.
  - ptr <= cand. ptr updates in both modes.
- No accept while load=1: out_valid <= 0. out_data, grant and ptr hold.
- load=0 (out_valid=1, out_ready=0): the output register holds. All in_ready=0.
- Latency and throughput:
  - Latency is 1 cycle from input acceptance to out_valid.
  - With out_ready held high, sustains one word per cycle with no bubbles.
- Handshake rules:
  - out_data and grant are stable while out_valid=1 and out_ready=0.
  - mode or select changes never disturb a held output word. They affect only the next acceptance.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grant sequence is 0,1,...,CHANNELS-1,0,... Each channel waits at most CHANNELS-1 accepts.
- Wrap-around: search index wraps from CHANNELS-1 to 0. This must be correct for non-power-of-two CHANNELS.
- Out-of-range select (mode=0, select>=CHANNELS):
  - cand_ok=0 and all in_ready=0.
  - A currently held word still drains normally.
- Mode switch 0->1: round-robin resumes from ptr, i.e. the last channel accepted under explicit select.
- Reset mid-operation: any held word is discarded immediately. No in_ready is asserted while rst=1.

Test Plan:
- Reset, then mode=0, select=2, CHANNELS=4, N=8, ch2 valid with 0xA5, out_ready=1 -> in_ready=4'b0100 in that cycle; next cycle out_valid=1, out_data=0xA5, grant=2.
- mode=1, all four channels valid with data 0x10,0x11,0x12,0x13, out_ready=1 for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3 with data matching; out_valid continuously 1.
- Word held, out_ready=0 for 3 cycles while select and inputs change -> out_data/grant unchanged, in_ready=0; on out_ready=1, next word is loaded in the same cycle the old one drains.
- mode=1, only ch1 and ch3 valid, ptr=1 -> grant=3 then 1 then 3 (skips invalid channels, wraps correctly); CHANNELS=3 build: all valid -> 0,1,2,0.
- mode=0, select=3 on a CHANNELS=3 build -> in_ready=0, out_valid falls to 0 after any held word drains.
- Assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, grant=0 immediately (asynchronous); after release, mode=1 first grant is channel 0.
